eth_rx_deframer: RTL

- Sits directly downstream of the RMII receive driver and consumes its dibit stream (dibit, dibit strobe, end-of-packet pulse).
- Assembles dibits into bytes LSB-first and checks the Ethernet FCS using the existing crc32 block.
- Holds back the trailing 4 FCS bytes so only payload bytes (dest MAC through data) reach the consumer.
- Reports frame status (ok, CRC/alignment/length errors, payload length) once per packet.

---
 rtl/eth_rx_deframer_pkg.sv | 33 +++
 rtl/eth_rx_deframer_crc32.sv | 25 ++
 rtl/eth_rx_deframer.sv | 108 ++++++++++
 3 files changed

// File: rtl/eth_rx_deframer_pkg.sv
// Shared constants, status record and CRC-32 step function for the RMII
// receive deframer.
package eth_rx_deframer_pkg;

    localparam logic [31:0] CRC_RESIDUE = 32'h2144DF1C;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;

    localparam int ETH_MIN_LEN = 64;
    localparam int ETH_MAX_LEN = 1518;
    localparam int ETH_FCS_LEN = 4;
    localparam int LEN_W       = 11;

    typedef struct packed {
        logic             ok;
        logic             crc;
        logic             align;
        logic             len;
        logic [LEN_W-1:0] frame_len;
    } frame_status_t;

    // Reflected CRC-32 register update for one dibit, bit 0 shifted in first.
    function automatic logic [31:0] crc32_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_rx_deframer_crc32.sv
// Dibit-serial Ethernet CRC-32; out is the complemented register, so a clean
// data+FCS stream leaves CRC_RESIDUE on out.
module eth_rx_deframer_crc32
    import eth_rx_deframer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  in,
    input  logic        inclk,
    output logic [31:0] out
);

    logic [31:0] crc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= CRC_INIT;
        end else if (inclk) begin
            crc_q <= crc32_dibit(crc_q, in);
        end
    end

    assign out = ~crc_q;

endmodule

// File: rtl/eth_rx_deframer.sv
// RMII dibit stream to payload bytes: LSB-first byte assembly, FCS hold-back
// through a 4-byte delay line, and a once-per-frame status report.
module eth_rx_deframer
    import eth_rx_deframer_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int MAX_LEN = ETH_MAX_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       in,
    input  logic             inclk,
    input  logic             done,
    output logic [7:0]       out,
    output logic             outclk,
    output logic             frame_end,
    output logic             frame_ok,
    output logic             err_crc,
    output logic             err_align,
    output logic             err_len,
    output logic [LEN_W-1:0] frame_len
);

    // Strobe semantics: outclk and frame_end are single-cycle qualifiers with
    // no backpressure; out and the status fields are valid while they are high.

    logic [1:0]       phase;
    logic [5:0]       acc;
    logic [LEN_W-1:0] count;
    logic [7:0]       dl [ETH_FCS_LEN];
    logic [2:0]       dl_fill;
    logic [31:0]      crc_out;
    logic             crc_clear;
    logic             take;
    logic             byte_done;
    logic [7:0]       new_byte;
    frame_status_t    status_q;
    frame_status_t    status_next;

    assign take      = inclk & ~done;
    assign byte_done = take & (phase == 2'd3);
    assign new_byte  = {in, acc};
    assign crc_clear = reset | done;

    eth_rx_deframer_crc32 u_crc32 (
        .clk   (clk),
        .reset (crc_clear),
        .in    (in),
        .inclk (inclk),
        .out   (crc_out)
    );

    always_comb begin
        status_next           = '0;
        status_next.align     = (phase != 2'd0);
        status_next.len       = (count < LEN_W'(MIN_LEN)) || (count > LEN_W'(MAX_LEN));
        status_next.crc       = (crc_out != CRC_RESIDUE);
        status_next.ok        = ~(status_next.align | status_next.len | status_next.crc);
        status_next.frame_len = (count >= LEN_W'(ETH_FCS_LEN)) ? count - LEN_W'(ETH_FCS_LEN) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= '0;
            acc       <= '0;
            count     <= '0;
            dl_fill   <= '0;
            out       <= '0;
            outclk    <= 1'b0;
            frame_end <= 1'b0;
            status_q  <= '0;
            for (int i = 0; i < ETH_FCS_LEN; i++) dl[i] <= '0;
        end else begin
            outclk    <= 1'b0;
            frame_end <= 1'b0;
            if (done) begin
                phase     <= '0;
                acc       <= '0;
                count     <= '0;
                dl_fill   <= '0;
                frame_end <= 1'b1;
                status_q  <= status_next;
            end else if (take) begin
                phase <= phase + 2'd1;
                if (phase != 2'd3) acc[{phase, 1'b0} +: 2] <= in;
                if (byte_done) begin
                    if (count != '1) count <= count + 1'b1;
                    dl[0] <= new_byte;
                    for (int i = 1; i < ETH_FCS_LEN; i++) dl[i] <= dl[i-1];
                    // Delay line full: the oldest byte is now known not to be FCS.
                    if (dl_fill == 3'(ETH_FCS_LEN)) begin
                        out    <= dl[ETH_FCS_LEN-1];
                        outclk <= 1'b1;
                    end else begin
                        dl_fill <= dl_fill + 3'd1;
                    end
                end
            end
        end
    end

    assign frame_ok  = status_q.ok;
    assign err_crc   = status_q.crc;
    assign err_align = status_q.align;
    assign err_len   = status_q.len;
    assign frame_len = status_q.frame_len;

endmodule
